// File: rtl/mc_pad_pkg.sv
// Shared types and defaults for the pad mux controller.
package mc_pad_pkg;

   typedef enum logic {
      ACTIVE = 1'b0,
      DRAIN  = 1'b1
   } mc_pad_mux_state_e;

   localparam int unsigned DefNumPads    = 8;
   localparam int unsigned DefNumSrcs    = 4;
   localparam int unsigned DefTurnCycles = 4;

   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mc_pad_mux_ctrl_if.sv
// Config port of the pad mux controller: request/grant plus one-cycle read response.
interface mc_pad_mux_ctrl_if #(
   parameter int unsigned NumPads = mc_pad_pkg::DefNumPads,
   parameter int unsigned NumSrcs = mc_pad_pkg::DefNumSrcs
);
   localparam int unsigned SelW  = mc_pad_pkg::clog2_min1(NumSrcs);
   localparam int unsigned AddrW = mc_pad_pkg::clog2_min1(NumPads);

   logic             cfg_req_i;
   logic             cfg_we_i;
   logic [AddrW-1:0] cfg_addr_i;
   logic [SelW-1:0]  cfg_wdata_i;
   logic             cfg_gnt_o;
   logic             cfg_rvalid_o;
   logic [SelW:0]    cfg_rdata_o;

   modport master (
      output cfg_req_i, cfg_we_i, cfg_addr_i, cfg_wdata_i,
      input  cfg_gnt_o, cfg_rvalid_o, cfg_rdata_o
   );

   modport slave (
      input  cfg_req_i, cfg_we_i, cfg_addr_i, cfg_wdata_i,
      output cfg_gnt_o, cfg_rvalid_o, cfg_rdata_o
   );

endinterface

// File: rtl/mc_pad_mux_chan.sv
// One pad: source select with break-before-make turnaround, registered pad outputs,
// and routing of the pad input back to the current owner only.
module mc_pad_mux_chan
   import mc_pad_pkg::*;
#(
   parameter int unsigned  NumSrcs    = DefNumSrcs,
   parameter int unsigned  TurnCycles = DefTurnCycles,
   localparam int unsigned SelW       = clog2_min1(NumSrcs)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               wr_i,
   input  logic [SelW-1:0]    wsel_i,
   input  logic [NumSrcs-1:0] src_d_i,
   input  logic [NumSrcs-1:0] src_oe_i,
   output logic [NumSrcs-1:0] src_d_o,
   output logic               pad_d_o,
   output logic               pad_oe_o,
   input  logic               pad_d_i,
   output logic [SelW-1:0]    cur_sel_o,
   output logic               busy_o
);

   localparam int unsigned     CntW      = clog2_min1(TurnCycles);
   localparam logic [CntW-1:0] CntReload = CntW'(TurnCycles - 1);

   mc_pad_mux_state_e state_q;
   logic [CntW-1:0]   cnt_q;
   logic [SelW-1:0]   cur_sel_q;
   logic [SelW-1:0]   pend_sel_q;
   logic              pad_d_q;
   logic              pad_oe_q;

   // oe drops on the same edge that enters DRAIN, so the pad is released
   // TurnCycles+1 cycles before the new owner's oe is registered.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ACTIVE;
         cnt_q      <= '0;
         cur_sel_q  <= '0;
         pend_sel_q <= '0;
         pad_d_q    <= 1'b0;
         pad_oe_q   <= 1'b0;
      end else begin
         pad_d_q <= src_d_i[cur_sel_q];
         unique case (state_q)
            ACTIVE: begin
               if (wr_i && (wsel_i != cur_sel_q)) begin
                  state_q    <= DRAIN;
                  pend_sel_q <= wsel_i;
                  cnt_q      <= CntReload;
                  pad_oe_q   <= 1'b0;
               end else begin
                  pad_oe_q <= src_oe_i[cur_sel_q];
               end
            end
            DRAIN: begin
               pad_oe_q <= 1'b0;
               if (wr_i) begin
                  pend_sel_q <= wsel_i;
                  cnt_q      <= CntReload;
               end else if (cnt_q == '0) begin
                  cur_sel_q <= pend_sel_q;
                  state_q   <= ACTIVE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: state_q <= ACTIVE;
         endcase
      end
   end

   always_comb begin
      src_d_o = '0;
      if (state_q == ACTIVE) src_d_o[cur_sel_q] = pad_d_i;
   end

   assign pad_d_o   = pad_d_q;
   assign pad_oe_o  = pad_oe_q;
   assign cur_sel_o = cur_sel_q;
   assign busy_o    = (state_q == DRAIN);

endmodule

// File: rtl/mc_pad_mux_ctrl.sv
// Pad mux controller: config decode and read response around one channel per pad.
module mc_pad_mux_ctrl
   import mc_pad_pkg::*;
#(
   parameter int unsigned NumPads    = DefNumPads,
   parameter int unsigned NumSrcs    = DefNumSrcs,
   parameter int unsigned TurnCycles = DefTurnCycles
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   mc_pad_mux_ctrl_if.slave                cfg,
   input  logic [NumSrcs-1:0][NumPads-1:0] src_d_i,
   input  logic [NumSrcs-1:0][NumPads-1:0] src_oe_i,
   output logic [NumSrcs-1:0][NumPads-1:0] src_d_o,
   output logic [NumPads-1:0]              pad_d_o,
   output logic [NumPads-1:0]              pad_oe_o,
   input  logic [NumPads-1:0]              pad_d_i
);

   localparam int unsigned SelW  = clog2_min1(NumSrcs);
   localparam int unsigned AddrW = clog2_min1(NumPads);

   logic                           addr_ok;
   logic                           wdata_ok;
   logic                           wr_ok;
   logic [NumPads-1:0][SelW-1:0]   cur_sel;
   logic [NumPads-1:0]             busy;
   logic                           rvalid_q;
   logic [SelW:0]                  rdata_q;
   logic [SelW:0]                  rdata_d;

   // Out-of-range addresses or selects are dropped before they reach any channel.
   assign addr_ok  = 32'(cfg.cfg_addr_i) < NumPads;
   assign wdata_ok = 32'(cfg.cfg_wdata_i) < NumSrcs;
   assign wr_ok    = cfg.cfg_req_i && cfg.cfg_we_i && addr_ok && wdata_ok;

   for (genvar p = 0; p < NumPads; p++) begin : g_pad
      logic [NumSrcs-1:0] col_d;
      logic [NumSrcs-1:0] col_oe;
      logic [NumSrcs-1:0] col_ret;

      for (genvar s = 0; s < NumSrcs; s++) begin : g_src
         assign col_d[s]       = src_d_i[s][p];
         assign col_oe[s]      = src_oe_i[s][p];
         assign src_d_o[s][p]  = col_ret[s];
      end

      mc_pad_mux_chan #(
         .NumSrcs    (NumSrcs),
         .TurnCycles (TurnCycles)
      ) u_chan (
         .clk_i     (clk_i),
         .rst_ni    (rst_ni),
         .wr_i      (wr_ok && (cfg.cfg_addr_i == AddrW'(p))),
         .wsel_i    (cfg.cfg_wdata_i),
         .src_d_i   (col_d),
         .src_oe_i  (col_oe),
         .src_d_o   (col_ret),
         .pad_d_o   (pad_d_o[p]),
         .pad_oe_o  (pad_oe_o[p]),
         .pad_d_i   (pad_d_i[p]),
         .cur_sel_o (cur_sel[p]),
         .busy_o    (busy[p])
      );
   end

   always_comb begin
      rdata_d = '0;
      if (addr_ok) rdata_d = {busy[cfg.cfg_addr_i], cur_sel[cfg.cfg_addr_i]};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= cfg.cfg_req_i;
         if (cfg.cfg_req_i) rdata_q <= rdata_d;
      end
   end

   assign cfg.cfg_gnt_o    = cfg.cfg_req_i;
   assign cfg.cfg_rvalid_o = rvalid_q;
   assign cfg.cfg_rdata_o  = rdata_q;

endmodule
